// File: rtl/bcd_countdown_converter.sv
// Binary-to-packed-BCD converter for the countdown display path.
// Range-limits the input, then runs shift-add-3 one input bit per clock.
module bcd_countdown_converter #(
    parameter int unsigned WIDTH    = 6,
    parameter int unsigned DIGITS   = 2,
    parameter int unsigned MAX_VAL  = 59,
    parameter bit          OVF_MODE = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [WIDTH-1:0]      data_i,
    output logic                  busy_o,
    output logic                  valid_o,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic                  ovf_o
);

    localparam int unsigned BcdW = 4 * DIGITS;
    localparam int unsigned CntW = (WIDTH + 1 > 2) ? $clog2(WIDTH + 1) : 1;
    localparam logic [WIDTH-1:0] MaxLim  = WIDTH'(MAX_VAL);
    localparam logic [CntW-1:0]  CntLoad = CntW'(WIDTH);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] bin_q, bin_d;
    logic [BcdW-1:0]  acc_q, acc_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             ovf_flag_q, ovf_flag_d;
    logic [BcdW-1:0]  bcd_q, bcd_d;
    logic             ovf_out_q, ovf_out_d;

    logic             in_range;
    logic [WIDTH-1:0] lim;
    logic [BcdW-1:0]  acc_adj;
    logic [BcdW+WIDTH-1:0] shifted;

    // Range limit applied before conversion so the accumulator never overflows.
    always_comb begin
        in_range = (data_i <= MaxLim);
        if (in_range) begin
            lim = data_i;
        end else if (OVF_MODE) begin
            lim = MaxLim;
        end else begin
            lim = '0;
        end
    end

    always_comb begin
        acc_adj = acc_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    assign shifted = {acc_adj[BcdW-2:0], bin_q, 1'b0};

    // State and datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= StIdle;
            bin_q      <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_flag_q <= 1'b0;
            bcd_q      <= '0;
            ovf_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bin_q      <= bin_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_flag_q <= ovf_flag_d;
            bcd_q      <= bcd_d;
            ovf_out_q  <= ovf_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = StShift;
            StShift: if (cnt_q == '0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // The cycle after the last shift publishes the result while entering DONE.
    always_comb begin
        bin_d      = bin_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_flag_d = ovf_flag_q;
        bcd_d      = bcd_q;
        ovf_out_d  = ovf_out_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    bin_d      = lim;
                    acc_d      = '0;
                    cnt_d      = CntLoad;
                    ovf_flag_d = ~in_range;
                end
            end
            StShift: begin
                if (cnt_q != '0) begin
                    acc_d = shifted[BcdW+WIDTH-1:WIDTH];
                    bin_d = shifted[WIDTH-1:0];
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    bcd_d     = acc_q;
                    ovf_out_d = ovf_flag_q;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        busy_o  = (state_q == StShift);
        valid_o = (state_q == StDone);
        bcd_o   = bcd_q;
        ovf_o   = ovf_out_q;
    end

endmodule
